alu_exec_stage: RTL and testbench

Sequential execute controller that sits directly upstream of the combinational MIPS `alu`. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads `rs`/`rt` from an internal 32×32 register file. It drives the ALU's `i_datain`/`gr1`/`gr2`, captures `c`/`zon`/`hi`/`lo`, then writes back the GPR, HI/LO and flag state, reporting branch outcome.

---
 rtl/mips_pkg.sv | 93 +++++++++
 rtl/mips_regfile.sv | 42 ++++
 rtl/alu_exec_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, FSM encoding and flag bit positions for the
// execute stage and its register file.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Bit positions inside the zero/overflow/negative flag vector
  localparam int ZON_Z = 2;
  localparam int ZON_O = 1;
  localparam int ZON_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Retire behaviour class of an instruction
  typedef enum logic [2:0] {
    K_NONE   = 3'd0,  // lw/sw/unknown: retire with no architectural write
    K_ALU_RD = 3'd1,  // R-type ALU op, result to rd
    K_ALU_RT = 3'd2,  // immediate ALU op, result to rt
    K_MULDIV = 3'd3,  // HI/LO update only
    K_MFHI   = 3'd4,
    K_MFLO   = 3'd5,
    K_BEQ    = 3'd6,
    K_BNE    = 3'd7
  } kind_t;

  function automatic kind_t decode_kind(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    decode_kind = K_NONE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA,
          FN_SRAV:                              decode_kind = K_ALU_RD;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   decode_kind = K_MULDIV;
          FN_MFHI:                              decode_kind = K_MFHI;
          FN_MFLO:                              decode_kind = K_MFLO;
          default:                              decode_kind = K_NONE;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
      OP_SLTIU:                                 decode_kind = K_ALU_RT;
      OP_BEQ:                                   decode_kind = K_BEQ;
      OP_BNE:                                   decode_kind = K_BNE;
      default:                                  decode_kind = K_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry GPR file: two operand read ports, a debug read port and one
// synchronous write port. Entry 0 is never written and always reads zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]  rs_data,
  output logic [DATA_W-1:0]  rt_data,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata
);

  localparam int DEPTH = 1 << RADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage: cleared on reset, written at the clock edge; $0 is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: $0 forced to zero regardless of storage contents.
  always_comb begin
    rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
    rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Four-state execute controller in front of the combinational MIPS ALU:
// accept -> read operands -> capture ALU results -> write back / retire.
module alu_exec_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [31:0]        alu_instr,
  output logic [DATA_W-1:0]  alu_gr1,
  output logic [DATA_W-1:0]  alu_gr2,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [2:0]         alu_zon,
  input  logic [DATA_W-1:0]  alu_hi,
  input  logic [DATA_W-1:0]  alu_lo,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               branch_taken,
  output logic [2:0]         zon_q,
  output logic [DATA_W-1:0]  hi_q,
  output logic [DATA_W-1:0]  lo_q,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t state_q, state_d;

  logic [31:0]        instr_q;
  logic [DATA_W-1:0]  gr1_q, gr2_q;
  logic [2:0]         zon_cap;
  logic [DATA_W-1:0]  hi_cap, lo_cap;
  logic [RADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               wb_we_q, br_q;

  logic [DATA_W-1:0]  rs_data, rt_data;
  kind_t              kind;
  logic [RADDR_W-1:0] rs_f, rt_f, rd_f, dest;
  logic               dest_wr;
  logic [DATA_W-1:0]  dest_data;
  logic               br_eval;

  // Field extraction and retire decisions from the latched instruction.
  always_comb begin
    kind      = decode_kind(instr_q);
    rs_f      = instr_q[25:21];
    rt_f      = instr_q[20:16];
    rd_f      = instr_q[15:11];
    dest      = (kind == K_ALU_RT) ? rt_f : rd_f;
    dest_wr   = 1'b0;
    dest_data = alu_c;
    br_eval   = 1'b0;
    case (kind)
      K_ALU_RD, K_ALU_RT: dest_wr = 1'b1;
      K_MFHI: begin dest_wr = 1'b1; dest_data = hi_q; end
      K_MFLO: begin dest_wr = 1'b1; dest_data = lo_q; end
      K_BEQ:  br_eval = alu_zon[ZON_Z];
      K_BNE:  br_eval = ~alu_zon[ZON_Z];
      default: ;
    endcase
    // Writes aimed at $0 are dropped here so wb_we reports them as no-write.
    if (dest == '0) dest_wr = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept only in IDLE, then walk READ/EXEC/WB unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers, each loaded in the single state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      gr1_q     <= '0;
      gr2_q     <= '0;
      zon_cap   <= '0;
      hi_cap    <= '0;
      lo_cap    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      br_q      <= 1'b0;
      zon_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (instr_valid) instr_q <= instr;
        ST_READ: begin
          gr1_q <= rs_data;
          gr2_q <= rt_data;
        end
        ST_EXEC: begin
          zon_cap   <= alu_zon;
          hi_cap    <= alu_hi;
          lo_cap    <= alu_lo;
          wb_addr_q <= dest;
          wb_data_q <= dest_data;
          wb_we_q   <= dest_wr;
          br_q      <= br_eval;
        end
        ST_WB: begin
          if (kind == K_MULDIV) begin
            hi_q <= hi_cap;
            lo_q <= lo_cap;
          end
          // mfhi/mflo only move data; flags keep the previous result.
          if (kind != K_MFHI && kind != K_MFLO) zon_q <= zon_cap;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, even mid-instruction.
  always_comb begin
    instr_ready  = (state_q == ST_IDLE) && !rst;
    wb_valid     = (state_q == ST_WB) && !rst;
    wb_we        = wb_valid && wb_we_q;
    branch_taken = wb_valid && br_q;
    alu_instr    = rst ? '0 : instr_q;
    alu_gr1      = rst ? '0 : gr1_q;
    alu_gr2      = rst ? '0 : gr2_q;
    wb_addr      = rst ? '0 : wb_addr_q;
    wb_data      = rst ? '0 : wb_data_q;
  end

  mips_regfile #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_f),
    .rt_addr  (rt_f),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .waddr    (wb_addr_q),
    .wdata    (wb_data_q)
  );

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a small behavioural ALU closes the loop, a table
// of instructions with hand-derived results drives the main checks, and a
// scoreboard queue matches every wb_valid pulse against its expectation.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_instr, alu_gr1, alu_gr2;
  logic [31:0] alu_c, alu_hi, alu_lo;
  logic [2:0]  alu_zon;
  logic        wb_valid, wb_we, branch_taken;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  zon_q;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_instr    (alu_instr),
    .alu_gr1      (alu_gr1),
    .alu_gr2      (alu_gr2),
    .alu_c        (alu_c),
    .alu_zon      (alu_zon),
    .alu_hi       (alu_hi),
    .alu_lo       (alu_lo),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .branch_taken (branch_taken),
    .zon_q        (zon_q),
    .hi_q         (hi_q),
    .lo_q         (lo_q),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU covering only the operations used below; anything else
  // yields c=0 so a stage that wrongly uses c for mfhi/mflo is exposed.
  always_comb begin
    logic [31:0] a, b, simm;
    longint      p;
    logic        ovf;
    a = alu_gr1; b = alu_gr2;
    simm = {{16{alu_instr[15]}}, alu_instr[15:0]};
    alu_c = 32'h0; alu_hi = 32'h0; alu_lo = 32'h0; ovf = 1'b0; p = 0;
    case (alu_instr[31:26])
      6'h00: case (alu_instr[5:0])
        6'h20: begin alu_c = a + b; ovf = (a[31] == b[31]) && (alu_c[31] != a[31]); end
        6'h22: begin alu_c = a - b; ovf = (a[31] != b[31]) && (alu_c[31] != a[31]); end
        6'h02: alu_c = b >> alu_instr[10:6];
        6'h18: begin
          p = longint'($signed(a)) * longint'($signed(b));
          alu_hi = p[63:32]; alu_lo = p[31:0];
        end
        default: alu_c = 32'h0;
      endcase
      6'h08: begin alu_c = a + simm; ovf = (a[31] == simm[31]) && (alu_c[31] != a[31]); end
      6'h0D: alu_c = a | {16'h0, alu_instr[15:0]};
      6'h04, 6'h05: alu_c = a - b;
      default: alu_c = 32'h0;
    endcase
    if (alu_instr[31:26] == 6'h00 && alu_instr[5:0] == 6'h18)
      alu_zon = {p == 0, 1'b0, p[63]};
    else
      alu_zon = {alu_c == 32'h0, ovf, alu_c[31]};
  end

  typedef struct {
    logic [31:0] ins;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        br;
    logic [2:0]  zon;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  dreg;
    logic [31:0] dval;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        br;
  } sb_t;

  sb_t sbq[$];
  int  acc_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0, acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: note accepts, and score every retire pulse against the queue.
  always @(negedge clk) begin
    sb_t e;
    int  a;
    cyc++;
    if (instr_valid && instr_ready) begin
      acc_q.push_back(cyc);
      acc_cnt++;
    end
    if (wb_valid) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wb_valid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("branch_taken", 32'(branch_taken), 32'(e.br));
        if (e.we) begin
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", wb_data, e.data);
        end
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          chk("latency", 32'(cyc - a), 32'd3);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #2; n++; end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 12) begin @(posedge clk); #2; n++; end
    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL retire_timeout actual=%0d pending required=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic issue(input vec_t v);
    sb_t e;
    wait_ready();
    e.we = v.we; e.addr = v.addr; e.data = v.data; e.br = v.br;
    sbq.push_back(e);
    instr = v.ins;
    instr_valid = 1'b1;
    @(posedge clk); #2;
    instr_valid = 1'b0;
    wait_drain();
    chk("zon_q", 32'(zon_q), 32'(v.zon));
    chk("hi_q", hi_q, v.hi);
    chk("lo_q", lo_q, v.lo);
    dbg_addr = v.dreg;
    #1;
    chk("dbg_data", dbg_data, v.dval);
  endtask

  vec_t vt[15];

  initial begin
    sb_t e;
    int  a0;
    // ins         we    addr  data          br    zon     hi            lo            dreg  dval
    vt[0]  = '{32'h34011234, 1'b1, 5'd1, 32'h00001234, 1'b0, 3'b000, 32'h0,        32'h0,        5'd1, 32'h00001234}; // ori $1,$0,0x1234
    vt[1]  = '{32'h2001FFFF, 1'b1, 5'd1, 32'hFFFFFFFF, 1'b0, 3'b001, 32'h0,        32'h0,        5'd1, 32'hFFFFFFFF}; // addi $1,$0,-1
    vt[2]  = '{32'h00010842, 1'b1, 5'd1, 32'h7FFFFFFF, 1'b0, 3'b000, 32'h0,        32'h0,        5'd1, 32'h7FFFFFFF}; // srl $1,$1,1
    vt[3]  = '{32'h34020001, 1'b1, 5'd2, 32'h00000001, 1'b0, 3'b000, 32'h0,        32'h0,        5'd2, 32'h00000001}; // ori $2,$0,1
    vt[4]  = '{32'h00221820, 1'b1, 5'd3, 32'h80000000, 1'b0, 3'b011, 32'h0,        32'h0,        5'd3, 32'h80000000}; // add $3,$1,$2
    vt[5]  = '{32'h2001FFFF, 1'b1, 5'd1, 32'hFFFFFFFF, 1'b0, 3'b001, 32'h0,        32'h0,        5'd1, 32'hFFFFFFFF}; // addi $1,$0,-1
    vt[6]  = '{32'h34020002, 1'b1, 5'd2, 32'h00000002, 1'b0, 3'b000, 32'h0,        32'h0,        5'd2, 32'h00000002}; // ori $2,$0,2
    vt[7]  = '{32'h00220018, 1'b0, 5'd0, 32'h0,        1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd1, 32'hFFFFFFFF}; // mult $1,$2
    vt[8]  = '{32'h00002012, 1'b1, 5'd4, 32'hFFFFFFFE, 1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd4, 32'hFFFFFFFE}; // mflo $4
    vt[9]  = '{32'h00002810, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd5, 32'hFFFFFFFF}; // mfhi $5
    vt[10] = '{32'h10210000, 1'b0, 5'd0, 32'h0,        1'b1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd3, 32'h80000000}; // beq $1,$1
    vt[11] = '{32'h14210000, 1'b0, 5'd0, 32'h0,        1'b0, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd4, 32'hFFFFFFFE}; // bne $1,$1
    vt[12] = '{32'h20000005, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd0, 32'h0};        // addi $0,$0,5
    vt[13] = '{32'hAC010000, 1'b0, 5'd0, 32'h0,        1'b0, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd2, 32'h00000002}; // sw
    vt[14] = '{32'h00223022, 1'b1, 5'd6, 32'hFFFFFFFD, 1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd6, 32'hFFFFFFFD}; // sub $6,$1,$2

    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", 32'(instr_ready), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_alu_instr", alu_instr, 32'h0);
    chk("reset_zon_q", 32'(zon_q), 32'd0);
    chk("reset_hi_q", hi_q, 32'h0);
    chk("reset_lo_q", lo_q, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 15; i++) issue(vt[i]);

    // Valid held high across a whole instruction: one accept per IDLE visit.
    wait_ready();
    a0 = acc_cnt;
    e.we = 1'b0; e.addr = 5'd0; e.data = 32'h0; e.br = 1'b0;
    sbq.push_back(e);
    sbq.push_back(e);
    instr = 32'h20000005;
    instr_valid = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    instr_valid = 1'b0;
    wait_drain();
    chk("held_valid_accepts", 32'(acc_cnt - a0), 32'd2);
    dbg_addr = 5'd0;
    #1;
    chk("dbg_r0", dbg_data, 32'h0);

    // Reset during EXEC of ori $5,$0,7: instruction dropped, no retire.
    wait_ready();
    instr = 32'h34050007;
    instr_valid = 1'b1;
    @(posedge clk); #2;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(instr_ready), 32'd0);
    chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mid_alu_instr", alu_instr, 32'h0);
    chk("rst_mid_alu_gr1", alu_gr1, 32'h0);
    chk("rst_mid_wb_data", wb_data, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    acc_q.delete();
    #1;
    chk("rst_mid_ready_after", 32'(instr_ready), 32'd1);
    dbg_addr = 5'd5;
    #1;
    chk("rst_mid_r5", dbg_data, 32'h0);
    dbg_addr = 5'd1;
    #1;
    chk("rst_clears_r1", dbg_data, 32'h0);
    repeat (4) @(posedge clk);
    #2;

    // The same instruction completes normally after reset.
    issue('{32'h34050007, 1'b1, 5'd5, 32'h00000007, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h00000007});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
